// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: round-robin grant between the ALU and
// the load unit. It registers one write per cycle onto the register enables
// and the bypass outputs.
module rf_write_arbiter #(
    parameter int unsigned bits            = 32,
    parameter int unsigned no_of_registers = 32
) (
    input  logic                         clk,
    input  logic                         async_reset,
    input  logic                         stall,
    input  logic                         valid0,
    input  logic [((no_of_registers > 1) ? $clog2(no_of_registers) : 1)-1:0] addr0,
    input  logic [bits-1:0]              data0,
    output logic                         ready0,
    input  logic                         valid1,
    input  logic [((no_of_registers > 1) ? $clog2(no_of_registers) : 1)-1:0] addr1,
    input  logic [bits-1:0]              data1,
    output logic                         ready1,
    output logic [no_of_registers-1:0]   rf_en,
    output logic                         sp_en,
    output logic [bits-1:0]              wr_data,
    output logic                         pend_valid,
    output logic [((no_of_registers > 1) ? $clog2(no_of_registers) : 1)-1:0] pend_addr,
    output logic [bits-1:0]              pend_data
);

    localparam int unsigned AW      = (no_of_registers > 1) ? $clog2(no_of_registers) : 1;
    localparam int unsigned SP_ADDR = 2;

    typedef enum logic {
        GRANT_P0 = 1'b0,
        GRANT_P1 = 1'b1
    } grant_e;

    // Power-up values match the reset values.
    grant_e                       r_last_grant = GRANT_P1;
    logic [no_of_registers-1:0]   r_rf_en      = '0;
    logic                         r_sp_en      = 1'b0;
    logic                         r_pend_valid = 1'b0;
    logic [AW-1:0]                r_pend_addr  = '0;
    logic [bits-1:0]              r_data       = '0;

    grant_e                       w_last_grant_nxt;
    logic                         w_gnt0;
    logic                         w_gnt1;
    logic                         w_xfer;
    logic [AW-1:0]                w_addr;
    logic [bits-1:0]              w_data;
    logic [no_of_registers-1:0]   w_rf_en;
    logic                         w_sp_en;

    // Last-grant state register.
    always_ff @(posedge clk) begin
        r_last_grant <= w_last_grant_nxt;
    end

    // Round-robin grant and last-grant update. On a tie, the port that did not win last time is granted.
    always_comb begin
        w_gnt0           = 1'b0;
        w_gnt1           = 1'b0;
        w_last_grant_nxt = r_last_grant;
        if (!stall && !async_reset) begin
            w_gnt0 = valid0 && (!valid1 || (r_last_grant == GRANT_P1));
            w_gnt1 = valid1 && (!valid0 || (r_last_grant == GRANT_P0));
        end
        if (async_reset) begin
            w_last_grant_nxt = GRANT_P1;
        end else if (w_gnt0) begin
            w_last_grant_nxt = GRANT_P0;
        end else if (w_gnt1) begin
            w_last_grant_nxt = GRANT_P1;
        end
    end

    // Winner mux and enable decode. x0 and out-of-range addresses are discarded, and address 2 goes to SP.
    always_comb begin
        w_xfer  = w_gnt0 || w_gnt1;
        w_addr  = w_gnt1 ? addr1 : addr0;
        w_data  = w_gnt1 ? data1 : data0;
        w_rf_en = '0;
        w_sp_en = (no_of_registers > SP_ADDR) && (32'(w_addr) == SP_ADDR);
        for (int unsigned i = 0; i < no_of_registers; i++) begin
            if ((i != 0) && (i != SP_ADDR)) begin
                w_rf_en[i] = (32'(w_addr) == i);
            end
        end
    end

    // Write pipeline register. Enables last one cycle per transfer, while the data and address hold.
    always_ff @(posedge clk) begin
        if (async_reset) begin
            r_rf_en      <= '0;
            r_sp_en      <= 1'b0;
            r_pend_valid <= 1'b0;
            r_pend_addr  <= '0;
            r_data       <= '0;
        end else if (w_xfer) begin
            r_rf_en      <= w_rf_en;
            r_sp_en      <= w_sp_en;
            r_pend_valid <= 1'b1;
            r_pend_addr  <= w_addr;
            r_data       <= w_data;
        end else begin
            r_rf_en      <= '0;
            r_sp_en      <= 1'b0;
            r_pend_valid <= 1'b0;
        end
    end

    assign ready0     = w_gnt0;
    assign ready1     = w_gnt1;
    assign rf_en      = r_rf_en;
    assign sp_en      = r_sp_en;
    assign wr_data    = r_data;
    assign pend_valid = r_pend_valid;
    assign pend_addr  = r_pend_addr;
    assign pend_data  = r_data;

endmodule
